dda_timer_multi: RTL and testbench

- Multi-channel successor to the single-axis DDA step timer.
- Consumes move segments from the shared move buffer using the stepready/stepfinished toggle-latch handshake.
- Runs NUM_CHANNELS DDA accumulators in lock-step against one clock-divided tick.
- Emits one-cycle step pulses with direction per channel; sits between the move-buffer state machine and the per-axis step/dir output drivers.

---
 rtl/dda_timer_multi.sv | 161 ++++++++++++++++
 tb/tb_dda_timer_multi.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dda_timer_multi.sv
// ---------------------------------------------------------------------------
// dda_timer_multi
//
// Multi-channel DDA step timer. Pulls move segments from the shared move
// buffer through the stepready/stepfinished toggle handshake. It then runs
// NUM_CHANNELS accumulators in lock-step on one clock-divided tick, and emits
// one-cycle step pulses with a direction bit per channel.
//
// Optional feature macro: DDA_ACCEL_EN
//   defined   -> incrementincrement port exists. Each channel's velocity
//                (inc_r) integrates its acceleration on every tick.
//   undefined -> no incrementincrement port. Velocity is constant for the
//                whole segment.
//
// Ports:
//   CLK                 system clock
//   resetn              asynchronous active-low reset
//   halt                synchronous active-low abort (resyncs the cursor)
//   clock_divisor       one tick every clock_divisor+1 CLK cycles
//   move_duration       ticks in the segment minus 1
//   increment           per-channel signed velocity; ch i at [i*ACC_WIDTH +: ACC_WIDTH]
//   incrementincrement  per-channel signed acceleration (DDA_ACCEL_EN only)
//   stepready           producer toggle per buffer slot
//   stepfinished        consumer toggle per buffer slot
//   writemoveind        producer cursor
//   moveind             consumer cursor
//   step                one-cycle step pulse per channel
//   dir                 direction of the last step per channel (1 forward)
//   move_done           one-cycle pulse when a segment completes
// ---------------------------------------------------------------------------
module dda_timer_multi #(
  parameter int NUM_CHANNELS = 3,
  parameter int ACC_WIDTH    = 64,
  parameter int DUR_WIDTH    = 64,
  parameter int DIV_WIDTH    = 8,
  parameter int BUFFER_DEPTH = 2,
  parameter int BUFFER_BITS  = 1,
  parameter logic [ACC_WIDTH-1:0] STEP_THRESHOLD = 64'h7fff_ffff_ffff_ff9b
) (
  input  logic                           CLK,
  input  logic                           resetn,
  input  logic                           halt,
  input  logic [DIV_WIDTH-1:0]           clock_divisor,
  input  logic [DUR_WIDTH-1:0]           move_duration,
  input  logic [NUM_CHANNELS*ACC_WIDTH-1:0] increment,
`ifdef DDA_ACCEL_EN
  input  logic [NUM_CHANNELS*ACC_WIDTH-1:0] incrementincrement,
`endif
  input  logic [BUFFER_DEPTH-1:0]        stepready,
  output logic [BUFFER_DEPTH-1:0]        stepfinished,
  input  logic [BUFFER_BITS-1:0]         writemoveind,
  output logic [BUFFER_BITS-1:0]         moveind,
  output logic [NUM_CHANNELS-1:0]        step,
  output logic [NUM_CHANNELS-1:0]        dir,
  output logic                           move_done
);

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  // Threshold as a signed value so both step directions use signed compares.
  localparam logic signed [ACC_WIDTH-1:0] THR_POS = STEP_THRESHOLD;
  localparam logic signed [ACC_WIDTH-1:0] THR_NEG = -THR_POS;

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc   [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]   inc_r [NUM_CHANNELS];
  logic [DUR_WIDTH-1:0]          tickdown;
  logic [DIV_WIDTH-1:0]          divcnt;
  logic                          pending;
  logic                          tick;

  // A slot holds work when the producer's toggle differs from ours.
  assign pending = (stepfinished[moveind] != stepready[moveind]);
  assign tick    = (divcnt == '0);

  // Whole timer in one registered process.
  // In RUN, a cycle is either a tick (accumulators integrate velocity) or a
  // step-evaluation cycle (at most one threshold crossing per channel is
  // taken off the accumulator). The two never write acc in the same cycle,
  // so a crossing that a tick creates shows up as a pulse two cycles later.
  // halt resynchronises the cursor to the producer and drops all
  // fractional progress. It takes priority over the normal sequencing.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state        <= LOAD;
      tickdown     <= '0;
      divcnt       <= '0;
      stepfinished <= '0;
      moveind      <= '0;
      step         <= '0;
      dir          <= '0;
      move_done    <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc[i]   <= '0;
        inc_r[i] <= '0;
      end
    end else if (!halt) begin
      state        <= LOAD;
      moveind      <= writemoveind;
      stepfinished <= stepready;
      step         <= '0;
      move_done    <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc[i] <= '0;
      end
    end else begin
      step      <= '0;
      move_done <= 1'b0;
      case (state)
        LOAD: begin
          if (pending) begin
            tickdown <= move_duration;
            divcnt   <= clock_divisor;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              inc_r[i] <= increment[i*ACC_WIDTH +: ACC_WIDTH];
            end
            state <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            divcnt   <= clock_divisor;
            tickdown <= tickdown - DUR_WIDTH'(1);
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              acc[i] <= acc[i] + inc_r[i];
`ifdef DDA_ACCEL_EN
              inc_r[i] <= inc_r[i] + $signed(incrementincrement[i*ACC_WIDTH +: ACC_WIDTH]);
`endif
            end
            // The final tick still integrates. Its residue is carried into
            // the next segment rather than evaluated here.
            if (tickdown == '0) begin
              stepfinished[moveind] <= ~stepfinished[moveind];
              moveind               <= moveind + BUFFER_BITS'(1);
              move_done             <= 1'b1;
              state                 <= LOAD;
            end
          end else begin
            divcnt <= divcnt - DIV_WIDTH'(1);
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              if (acc[i] >= THR_POS) begin
                step[i] <= 1'b1;
                dir[i]  <= 1'b1;
                acc[i]  <= acc[i] - THR_POS;
              end else if (acc[i] <= THR_NEG) begin
                step[i] <= 1'b1;
                dir[i]  <= 1'b0;
                acc[i]  <= acc[i] + THR_POS;
              end
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_timer_multi.sv
// ---------------------------------------------------------------------------
// tb_dda_timer_multi
//
// Self-checking bench for dda_timer_multi. Each segment is predicted with a
// tick-level arithmetic model: a step check precedes every tick when the
// divisor leaves room for one, and the velocity is added with 64-bit wrap.
// The bench then compares step counts per direction, final dir,
// move_done timing, and the handshake cursor/toggles against the DUT.
// Build with DDA_ACCEL_EN defined to also exercise acceleration.
// ---------------------------------------------------------------------------
module tb_dda_timer_multi;

  localparam int NCH = 3;
  localparam logic signed [63:0] THR = 64'h7fff_ffff_ffff_ff9b;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         halt;
  logic [7:0]   clock_divisor;
  logic [63:0]  move_duration;
  logic [191:0] increment;
`ifdef DDA_ACCEL_EN
  logic [191:0] incrementincrement;
`endif
  logic [1:0]   stepready;
  logic [1:0]   stepfinished;
  logic         writemoveind;
  logic         moveind;
  logic [2:0]   step;
  logic [2:0]   dir;
  logic         move_done;

  dda_timer_multi dut (
    .CLK               (CLK),
    .resetn            (resetn),
    .halt              (halt),
    .clock_divisor     (clock_divisor),
    .move_duration     (move_duration),
    .increment         (increment),
`ifdef DDA_ACCEL_EN
    .incrementincrement(incrementincrement),
`endif
    .stepready         (stepready),
    .stepfinished      (stepfinished),
    .writemoveind      (writemoveind),
    .moveind           (moveind),
    .step              (step),
    .dir               (dir),
    .move_done         (move_done)
  );

  always #5 CLK = ~CLK;

  // Free-running posedge count used to timestamp move_done.
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observed activity, sampled on the falling edge.
  int          fwd_cnt [NCH];
  int          rev_cnt [NCH];
  int unsigned done_q  [$];

  always @(negedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (step[i] === 1'b1) begin
        if (dir[i]) fwd_cnt[i]++;
        else        rev_cnt[i]++;
      end
    end
    if (move_done === 1'b1) done_q.push_back(cyc);
  end

  // Reference model state.
  logic signed [63:0] m_acc    [NCH];
  logic               m_dir    [NCH];
  bit                 m_dir_ok [NCH];
  int                 m_fwd    [NCH];
  int                 m_rev    [NCH];
  logic [1:0]         m_sf;
  logic               m_ind;
  logic signed [63:0] s_inc    [NCH];
  logic signed [63:0] s_acl    [NCH];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = '0; m_dir[i] = 1'b0; m_dir_ok[i] = 1'b1;
    end
    m_sf  = '0;
    m_ind = 1'b0;
  endtask

  task automatic modelEval(input int i);
    if (m_acc[i] >= THR) begin
      m_acc[i] -= THR; m_fwd[i]++; m_dir[i] = 1'b1; m_dir_ok[i] = 1'b1;
    end else if (m_acc[i] <= -THR) begin
      m_acc[i] += THR; m_rev[i]++; m_dir[i] = 1'b0; m_dir_ok[i] = 1'b1;
    end
  endtask

  // One segment = n+1 ticks. With a divisor of at least 1, each tick is
  // preceded by one threshold check. The last tick's residue stays pending.
  task automatic modelSegment(input int n, input int d);
    logic signed [63:0] v [NCH];
    for (int i = 0; i < NCH; i++) v[i] = s_inc[i];
    for (int t = 0; t <= n; t++) begin
      for (int i = 0; i < NCH; i++) begin
        if (d >= 1) modelEval(i);
        m_acc[i] += v[i];
        v[i]     += s_acl[i];
      end
    end
    m_sf[m_ind] = ~m_sf[m_ind];
    m_ind       = m_ind + 1'b1;
  endtask

  task automatic driveInputs(input int n, input int d);
    clock_divisor = 8'(d);
    move_duration = 64'(n);
    for (int i = 0; i < NCH; i++) begin
      increment[i*64 +: 64] = s_inc[i];
`ifdef DDA_ACCEL_EN
      incrementincrement[i*64 +: 64] = s_acl[i];
`endif
    end
    for (int i = 0; i < NCH; i++) begin
      fwd_cnt[i] = 0; rev_cnt[i] = 0; m_fwd[i] = 0; m_rev[i] = 0;
    end
    done_q.delete();
  endtask

  // Posts k back-to-back segments with shared parameters and checks the result.
  task automatic applyStimulus(input int k, input int n, input int d);
    int unsigned c0;
    int          seg;
    int          budget;
    @(negedge CLK);
    driveInputs(n, d);
    for (int j = 0; j < k; j++) stepready[(int'(m_ind) + j) % 2] ^= 1'b1;
    c0 = cyc;
    for (int j = 0; j < k; j++) modelSegment(n, d);
    seg    = (n + 1) * (d + 1);
    budget = k * (seg + 1) + 20;
    for (int w = 0; w < budget && done_q.size() < k; w++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    checkOutput("done_count", 64'(done_q.size()), 64'(k));
    if (done_q.size() >= 1) checkOutput("done_time", 64'(done_q[0]), 64'(c0 + 1 + seg));
    if (k == 2 && done_q.size() >= 2)
      checkOutput("done_gap", 64'(done_q[1] - done_q[0]), 64'(seg + 1));
    for (int i = 0; i < NCH; i++) begin
      checkOutput($sformatf("fwd_steps_ch%0d", i), 64'(fwd_cnt[i]), 64'(m_fwd[i]));
      checkOutput($sformatf("rev_steps_ch%0d", i), 64'(rev_cnt[i]), 64'(m_rev[i]));
      if (m_dir_ok[i]) checkOutput($sformatf("dir_ch%0d", i), 64'(dir[i]), 64'(m_dir[i]));
    end
    checkOutput("stepfinished", 64'(stepfinished), 64'(m_sf));
    checkOutput("moveind", 64'(moveind), 64'(m_ind));
  endtask

  task automatic randomSegment();
    logic signed [63:0] dv;
    for (int i = 0; i < NCH; i++) begin
      dv       = 64'($urandom_range(2, 12));
      s_inc[i] = ($urandom_range(0, 4) == 0) ? 64'sd0 : THR / dv;
      if ($urandom_range(0, 1) == 1) s_inc[i] = -s_inc[i];
      s_acl[i] = '0;
`ifdef DDA_ACCEL_EN
      s_acl[i] = (THR / 2048) * $signed(64'($urandom_range(0, 4)) - 64'sd2);
`endif
    end
  endtask

  initial begin
    resetn        = 1'b0;
    halt          = 1'b1;
    stepready     = '0;
    writemoveind  = 1'b0;
    clock_divisor = '0;
    move_duration = '0;
    increment     = '0;
`ifdef DDA_ACCEL_EN
    incrementincrement = '0;
`endif
    for (int i = 0; i < NCH; i++) begin s_inc[i] = '0; s_acl[i] = '0; end
    modelReset();

    // Reset values, then a long idle window with nothing pending.
    repeat (3) @(negedge CLK);
    checkOutput("rst_step", 64'(step), 64'd0);
    checkOutput("rst_dir", 64'(dir), 64'd0);
    checkOutput("rst_done", 64'(move_done), 64'd0);
    checkOutput("rst_sf", 64'(stepfinished), 64'd0);
    checkOutput("rst_moveind", 64'(moveind), 64'd0);
    resetn = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      checkOutput("idle_step_done", 64'({step, move_done}), 64'd0);
    end
    checkOutput("idle_moveind", 64'(moveind), 64'd0);
    checkOutput("idle_sf", 64'(stepfinished), 64'd0);

    // Half-threshold forward velocity on ch0, divisor 1, 10 ticks.
    s_inc[0] = THR / 2; s_inc[1] = '0; s_inc[2] = '0;
    applyStimulus(1, 9, 1);

    // Quarter-threshold reverse velocity on ch1, 8 ticks.
    s_inc[0] = '0; s_inc[1] = -(THR / 4); s_inc[2] = '0;
    applyStimulus(1, 7, 1);

    // Both slots pending back to back; the cursor wraps.
    randomSegment();
    applyStimulus(2, 5, 2);

    // Divisor 0: every cycle ticks, so no step checks inside the segment.
    randomSegment();
    applyStimulus(1, 4, 0);

`ifdef DDA_ACCEL_EN
    // Pure acceleration from rest on ch0.
    for (int i = 0; i < NCH; i++) begin s_inc[i] = '0; s_acl[i] = '0; end
    s_acl[0] = THR / 64;
    applyStimulus(1, 15, 1);
    for (int i = 0; i < NCH; i++) s_acl[i] = '0;
`endif

    // Abort mid-segment after three quarter-threshold ticks (no step yet).
    @(negedge CLK);
    for (int i = 0; i < NCH; i++) begin s_inc[i] = THR / 4; s_acl[i] = '0; end
    driveInputs(100, 1);
    stepready[m_ind] ^= 1'b1;
    repeat (7) @(negedge CLK);
    halt         = 1'b0;
    writemoveind = 1'b1;
    stepready    = 2'b10;
    @(negedge CLK);
    checkOutput("halt_moveind", 64'(moveind), 64'd1);
    checkOutput("halt_sf", 64'(stepfinished), 64'h2);
    checkOutput("halt_step", 64'(step), 64'd0);
    checkOutput("halt_no_done", 64'(done_q.size()), 64'd0);
    halt = 1'b1;
    for (int i = 0; i < NCH; i++) m_acc[i] = '0;
    m_ind = 1'b1;
    m_sf  = 2'b10;
    repeat (3) @(negedge CLK);
    checkOutput("halt_idle_moveind", 64'(moveind), 64'd1);
    checkOutput("halt_no_steps", 64'(fwd_cnt[0] + fwd_cnt[1] + fwd_cnt[2]), 64'd0);

    // A stale residue of 3/4 threshold would step here; cleared acc does not.
    s_inc[0] = THR / 4; s_inc[1] = '0; s_inc[2] = '0;
    applyStimulus(1, 2, 1);

    // Randomised segments.
    for (int b = 0; b < 25; b++) begin
      randomSegment();
      applyStimulus(int'($urandom_range(1, 2)), int'($urandom_range(0, 12)),
                    ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3)));
    end

    // Asynchronous reset in the middle of a segment.
    @(negedge CLK);
    randomSegment();
    driveInputs(50, 2);
    stepready[m_ind] ^= 1'b1;
    repeat (20) @(negedge CLK);
    #2;
    resetn    = 1'b0;
    stepready = '0;
    #1;
    checkOutput("arst_moveind", 64'(moveind), 64'd0);
    checkOutput("arst_sf", 64'(stepfinished), 64'd0);
    checkOutput("arst_step_dir", 64'({step, dir}), 64'd0);
    checkOutput("arst_done", 64'(move_done), 64'd0);
    @(negedge CLK);
    resetn = 1'b1;
    modelReset();
    randomSegment();
    applyStimulus(2, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
